// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// Shared types for cache_mem_arbiter: FSM encodings, read-request capture struct
// and the address alignment helper used by both the read and write paths.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam int unsigned WORD_BYTES         = 4;
  localparam int unsigned LINE_WORDS_DEFAULT = 4;

  function automatic int unsigned line_off_w(input int unsigned line_words);
    return $clog2(WORD_BYTES * line_words);
  endfunction

  localparam int unsigned LINE_OFF_W_DEFAULT = line_off_w(LINE_WORDS_DEFAULT);

  typedef struct packed {
    logic [31:0] addr;
    logic        single;
    owner_e      owner;
  } rd_req_t;

  // Cached accesses drop the whole line offset; single-word accesses only the byte offset.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic single,
                                             input int unsigned off_w);
    logic [31:0] mask;
    mask = single ? 32'hFFFF_FFFC : ~((32'h1 << off_w) - 32'h1);
    return addr & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_mem_wr_buf.sv
`default_nettype none
// Single-entry dcache write buffer: captures a line or single store, bursts it to
// memory, waits for the write response and flags reads that hit the buffered line.
module cache_mem_arbiter_mem_wr_buf
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_req_i,
  input  logic [31:0]                wr_addr_i,
  input  logic                       wr_single_i,
  input  logic [3:0]                 wr_strb_i,
  input  logic [32*LINE_WORDS-1:0]   wr_data_i,
  output logic                       wr_rdy_o,
  output logic                       mem_wr_req_o,
  output logic [31:0]                mem_wr_addr_o,
  output logic [7:0]                 mem_wr_len_o,
  input  logic                       mem_wr_ready_i,
  output logic                       mem_wr_valid_o,
  output logic                       mem_wr_last_o,
  output logic [31:0]                mem_wr_data_o,
  output logic [3:0]                 mem_wr_strb_o,
  input  logic                       mem_wr_data_ready_i,
  input  logic                       mem_wr_done_i,
  input  logic [31:0]                chk_a_addr_i,
  input  logic [31:0]                chk_b_addr_i,
  output logic                       hit_a_o,
  output logic                       hit_b_o
);

  localparam int unsigned     OFF_W     = line_off_w(LINE_WORDS);
  localparam int unsigned     CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0]      BURST_LEN = 8'(LINE_WORDS - 1);

  wr_state_e                    state_q;
  logic [31:0]                  addr_q;
  logic [3:0]                   strb_q;
  logic                         single_q;
  logic [LINE_WORDS-1:0][31:0]  data_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         beat_last;
  logic                         busy;

  assign beat_last = single_q || (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= W_IDLE;
      addr_q   <= '0;
      strb_q   <= '0;
      single_q <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        W_IDLE: if (wr_req_i) begin
          addr_q   <= align_addr(wr_addr_i, wr_single_i, OFF_W);
          strb_q   <= wr_single_i ? wr_strb_i : 4'hF;
          single_q <= wr_single_i;
          data_q   <= wr_data_i;
          state_q  <= W_ADDR;
        end
        W_ADDR: if (mem_wr_ready_i) begin
          cnt_q   <= '0;
          state_q <= W_DATA;
        end
        W_DATA: if (mem_wr_data_ready_i) begin
          if (beat_last) state_q <= W_RESP;
          else           cnt_q   <= cnt_q + 1'b1;
        end
        W_RESP: if (mem_wr_done_i) state_q <= W_IDLE;
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign wr_rdy_o       = (state_q == W_IDLE) && wr_req_i;
  assign mem_wr_req_o   = (state_q == W_ADDR);
  assign mem_wr_addr_o  = mem_wr_req_o ? addr_q : '0;
  assign mem_wr_len_o   = mem_wr_req_o ? (single_q ? 8'd0 : BURST_LEN) : '0;
  assign mem_wr_valid_o = (state_q == W_DATA);
  assign mem_wr_last_o  = mem_wr_valid_o && beat_last;
  assign mem_wr_data_o  = mem_wr_valid_o ? data_q[cnt_q] : '0;
  assign mem_wr_strb_o  = mem_wr_valid_o ? strb_q : '0;

  // The buffer stays a hazard until the response cycle has retired it.
  assign busy    = (state_q != W_IDLE);
  assign hit_a_o = busy && (align_addr(chk_a_addr_i, 1'b0, OFF_W) == align_addr(addr_q, 1'b0, OFF_W));
  assign hit_b_o = busy && (align_addr(chk_b_addr_i, 1'b0, OFF_W) == align_addr(addr_q, 1'b0, OFF_W));

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// Arbitrates icache/dcache reads onto one memory read channel (round-robin, one
// outstanding) and forwards dcache writes through the write buffer.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      ic_rd_req_i,
  input  logic [31:0]               ic_rd_addr_i,
  input  logic                      ic_rd_single_i,
  output logic                      ic_rd_rdy_o,
  output logic                      ic_ret_valid_o,
  output logic                      ic_ret_last_o,
  output logic [31:0]               ic_ret_data_o,
  input  logic                      dc_rd_req_i,
  input  logic [31:0]               dc_rd_addr_i,
  input  logic                      dc_rd_single_i,
  output logic                      dc_rd_rdy_o,
  output logic                      dc_ret_valid_o,
  output logic                      dc_ret_last_o,
  output logic [31:0]               dc_ret_data_o,
  input  logic                      dc_wr_req_i,
  input  logic [31:0]               dc_wr_addr_i,
  input  logic                      dc_wr_single_i,
  input  logic [3:0]                dc_wr_strb_i,
  input  logic [32*LINE_WORDS-1:0]  dc_wr_data_i,
  output logic                      dc_wr_rdy_o,
  output logic                      mem_rd_req_o,
  output logic [31:0]               mem_rd_addr_o,
  output logic [7:0]                mem_rd_len_o,
  input  logic                      mem_rd_ready_i,
  input  logic                      mem_rd_valid_i,
  input  logic                      mem_rd_last_i,
  input  logic [31:0]               mem_rd_data_i,
  output logic                      mem_wr_req_o,
  output logic [31:0]               mem_wr_addr_o,
  output logic [7:0]                mem_wr_len_o,
  input  logic                      mem_wr_ready_i,
  output logic                      mem_wr_valid_o,
  output logic                      mem_wr_last_o,
  output logic [31:0]               mem_wr_data_o,
  output logic [3:0]                mem_wr_strb_o,
  input  logic                      mem_wr_data_ready_i,
  input  logic                      mem_wr_done_i
);

  localparam int unsigned OFF_W     = line_off_w(LINE_WORDS);
  localparam logic [7:0]  BURST_LEN = 8'(LINE_WORDS - 1);

  rd_state_e rd_state_q;
  rd_req_t   req_q;
  rd_req_t   req_d;
  owner_e    last_winner_q;
  logic      ic_hit, dc_hit;
  logic      ic_elig, dc_elig;
  logic      grant_ic, grant_dc;
  logic      beat_ok;

  cache_mem_arbiter_mem_wr_buf #(.LINE_WORDS(LINE_WORDS)) u_wr_buf (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .wr_req_i            (dc_wr_req_i),
    .wr_addr_i           (dc_wr_addr_i),
    .wr_single_i         (dc_wr_single_i),
    .wr_strb_i           (dc_wr_strb_i),
    .wr_data_i           (dc_wr_data_i),
    .wr_rdy_o            (dc_wr_rdy_o),
    .mem_wr_req_o        (mem_wr_req_o),
    .mem_wr_addr_o       (mem_wr_addr_o),
    .mem_wr_len_o        (mem_wr_len_o),
    .mem_wr_ready_i      (mem_wr_ready_i),
    .mem_wr_valid_o      (mem_wr_valid_o),
    .mem_wr_last_o       (mem_wr_last_o),
    .mem_wr_data_o       (mem_wr_data_o),
    .mem_wr_strb_o       (mem_wr_strb_o),
    .mem_wr_data_ready_i (mem_wr_data_ready_i),
    .mem_wr_done_i       (mem_wr_done_i),
    .chk_a_addr_i        (ic_rd_addr_i),
    .chk_b_addr_i        (dc_rd_addr_i),
    .hit_a_o             (ic_hit),
    .hit_b_o             (dc_hit)
  );

  // Hazard uses the pre-capture buffer state, so a same-cycle write does not block.
  always_comb begin
    ic_elig  = ic_rd_req_i && !ic_hit;
    dc_elig  = dc_rd_req_i && !dc_hit;
    grant_dc = (rd_state_q == R_IDLE) && dc_elig && (!ic_elig || (last_winner_q == OWN_IC));
    grant_ic = (rd_state_q == R_IDLE) && ic_elig && (!dc_elig || (last_winner_q == OWN_DC));
    if (grant_dc) begin
      req_d = '{addr: align_addr(dc_rd_addr_i, dc_rd_single_i, OFF_W),
                single: dc_rd_single_i, owner: OWN_DC};
    end else begin
      req_d = '{addr: align_addr(ic_rd_addr_i, ic_rd_single_i, OFF_W),
                single: ic_rd_single_i, owner: OWN_IC};
    end
  end

  assign ic_rd_rdy_o = grant_ic;
  assign dc_rd_rdy_o = grant_dc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_q    <= R_IDLE;
      req_q         <= '0;
      last_winner_q <= OWN_IC;
    end else begin
      case (rd_state_q)
        R_IDLE: if (grant_ic || grant_dc) begin
          req_q         <= req_d;
          last_winner_q <= req_d.owner;
          rd_state_q    <= R_ADDR;
        end
        R_ADDR: if (mem_rd_ready_i) rd_state_q <= R_DATA;
        R_DATA: if (mem_rd_valid_i && mem_rd_last_i) rd_state_q <= R_IDLE;
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign mem_rd_req_o  = (rd_state_q == R_ADDR);
  assign mem_rd_addr_o = mem_rd_req_o ? req_q.addr : '0;
  assign mem_rd_len_o  = mem_rd_req_o ? (req_q.single ? 8'd0 : BURST_LEN) : '0;

  assign beat_ok        = (rd_state_q == R_DATA) && mem_rd_valid_i;
  assign ic_ret_valid_o = beat_ok && (req_q.owner == OWN_IC);
  assign dc_ret_valid_o = beat_ok && (req_q.owner == OWN_DC);
  assign ic_ret_last_o  = ic_ret_valid_o && mem_rd_last_i;
  assign dc_ret_last_o  = dc_ret_valid_o && mem_rd_last_i;
  assign ic_ret_data_o  = ic_ret_valid_o ? mem_rd_data_i : '0;
  assign dc_ret_data_o  = dc_ret_valid_o ? mem_rd_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// Directed bench for cache_mem_arbiter: the bench plays the memory and scoreboards
// expected grants and return beats.
module tb_cache_mem_arbiter;

  localparam int unsigned LW = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            ic_rd_req_i, ic_rd_single_i, ic_rd_rdy_o;
  logic [31:0]     ic_rd_addr_i;
  logic            ic_ret_valid_o, ic_ret_last_o;
  logic [31:0]     ic_ret_data_o;
  logic            dc_rd_req_i, dc_rd_single_i, dc_rd_rdy_o;
  logic [31:0]     dc_rd_addr_i;
  logic            dc_ret_valid_o, dc_ret_last_o;
  logic [31:0]     dc_ret_data_o;
  logic            dc_wr_req_i, dc_wr_single_i, dc_wr_rdy_o;
  logic [31:0]     dc_wr_addr_i;
  logic [3:0]      dc_wr_strb_i;
  logic [32*LW-1:0] dc_wr_data_i;
  logic            mem_rd_req_o, mem_rd_ready_i, mem_rd_valid_i, mem_rd_last_i;
  logic [31:0]     mem_rd_addr_o, mem_rd_data_i;
  logic [7:0]      mem_rd_len_o;
  logic            mem_wr_req_o, mem_wr_ready_i, mem_wr_valid_o, mem_wr_last_o;
  logic [31:0]     mem_wr_addr_o, mem_wr_data_o;
  logic [7:0]      mem_wr_len_o;
  logic [3:0]      mem_wr_strb_o;
  logic            mem_wr_data_ready_i, mem_wr_done_i;

  typedef struct packed {
    logic        own;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  logic  grant_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .ic_rd_req_i(ic_rd_req_i), .ic_rd_addr_i(ic_rd_addr_i), .ic_rd_single_i(ic_rd_single_i),
    .ic_rd_rdy_o(ic_rd_rdy_o), .ic_ret_valid_o(ic_ret_valid_o), .ic_ret_last_o(ic_ret_last_o),
    .ic_ret_data_o(ic_ret_data_o),
    .dc_rd_req_i(dc_rd_req_i), .dc_rd_addr_i(dc_rd_addr_i), .dc_rd_single_i(dc_rd_single_i),
    .dc_rd_rdy_o(dc_rd_rdy_o), .dc_ret_valid_o(dc_ret_valid_o), .dc_ret_last_o(dc_ret_last_o),
    .dc_ret_data_o(dc_ret_data_o),
    .dc_wr_req_i(dc_wr_req_i), .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_single_i(dc_wr_single_i),
    .dc_wr_strb_i(dc_wr_strb_i), .dc_wr_data_i(dc_wr_data_i), .dc_wr_rdy_o(dc_wr_rdy_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_len_o(mem_rd_len_o),
    .mem_rd_ready_i(mem_rd_ready_i), .mem_rd_valid_i(mem_rd_valid_i),
    .mem_rd_last_i(mem_rd_last_i), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_req_o(mem_wr_req_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_len_o(mem_wr_len_o),
    .mem_wr_ready_i(mem_wr_ready_i), .mem_wr_valid_o(mem_wr_valid_o),
    .mem_wr_last_o(mem_wr_last_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_wr_strb_o(mem_wr_strb_o), .mem_wr_data_ready_i(mem_wr_data_ready_i),
    .mem_wr_done_i(mem_wr_done_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat();
    beat_t b;
    b = exp_q.pop_front();
    if (b.own) begin
      chk("dc_ret_valid", {63'd0, dc_ret_valid_o}, 64'd1);
      chk("dc_ret_data", {32'd0, dc_ret_data_o}, {32'd0, b.data});
      chk("dc_ret_last", {63'd0, dc_ret_last_o}, {63'd0, b.last});
      chk("ic_ret_quiet", {63'd0, ic_ret_valid_o}, 64'd0);
    end else begin
      chk("ic_ret_valid", {63'd0, ic_ret_valid_o}, 64'd1);
      chk("ic_ret_data", {32'd0, ic_ret_data_o}, {32'd0, b.data});
      chk("ic_ret_last", {63'd0, ic_ret_last_o}, {63'd0, b.last});
      chk("dc_ret_quiet", {63'd0, dc_ret_valid_o}, 64'd0);
    end
  endtask

  // Entered settled in R_ADDR; leaves settled in R_IDLE after the last beat.
  task automatic serve_read(input logic own, input logic [31:0] a, input logic [7:0] len,
                            input logic [31:0] base);
    chk("mem_rd_req", {63'd0, mem_rd_req_o}, 64'd1);
    chk("mem_rd_addr", {32'd0, mem_rd_addr_o}, {32'd0, a});
    chk("mem_rd_len", {56'd0, mem_rd_len_o}, {56'd0, len});
    mem_rd_ready_i = 1'b1;
    tick();
    mem_rd_ready_i = 1'b0;
    settle();
    chk("mem_rd_req_drop", {63'd0, mem_rd_req_o}, 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      mem_rd_valid_i = 1'b1;
      mem_rd_data_i  = base + i;
      mem_rd_last_i  = (i == int'(len));
      exp_q.push_back('{own: own, data: base + i, last: (i == int'(len))});
      settle();
      check_beat();
      tick();
    end
    mem_rd_valid_i = 1'b0;
    mem_rd_last_i  = 1'b0;
    mem_rd_data_i  = '0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [LW];
    logic        exp_own;

    reset_i = 1'b1;
    ic_rd_req_i = 0; ic_rd_addr_i = 0; ic_rd_single_i = 0;
    dc_rd_req_i = 0; dc_rd_addr_i = 0; dc_rd_single_i = 0;
    dc_wr_req_i = 0; dc_wr_addr_i = 0; dc_wr_single_i = 0; dc_wr_strb_i = 0; dc_wr_data_i = '0;
    mem_rd_ready_i = 0; mem_rd_valid_i = 0; mem_rd_last_i = 0; mem_rd_data_i = 0;
    mem_wr_ready_i = 0; mem_wr_data_ready_i = 0; mem_wr_done_i = 0;
    tick();
    tick();
    reset_i = 1'b0;
    settle();

    // Reset state
    chk("rst_mem_rd_req", {63'd0, mem_rd_req_o}, 64'd0);
    chk("rst_mem_rd_len", {56'd0, mem_rd_len_o}, 64'd0);
    chk("rst_mem_wr_req", {63'd0, mem_wr_req_o}, 64'd0);
    chk("rst_mem_wr_len", {56'd0, mem_wr_len_o}, 64'd0);
    chk("rst_mem_wr_valid", {63'd0, mem_wr_valid_o}, 64'd0);
    chk("rst_dc_wr_rdy", {63'd0, dc_wr_rdy_o}, 64'd0);
    chk("rst_rets", {62'd0, ic_ret_valid_o, dc_ret_valid_o}, 64'd0);

    // Round-robin with both requesting: dcache, icache, dcache
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    ic_rd_req_i = 1; ic_rd_addr_i = 32'h0000_0104; ic_rd_single_i = 0;
    dc_rd_req_i = 1; dc_rd_addr_i = 32'h0000_0208; dc_rd_single_i = 0;
    settle();
    for (int g = 0; g < 3; g++) begin
      exp_own = grant_q.pop_front();
      chk("grant_dc_rdy", {63'd0, dc_rd_rdy_o}, {63'd0, exp_own});
      chk("grant_ic_rdy", {63'd0, ic_rd_rdy_o}, {63'd0, !exp_own});
      tick();
      settle();
      serve_read(exp_own, exp_own ? 32'h0000_0200 : 32'h0000_0100, 8'd3, 32'h100 * (g + 1));
    end
    ic_rd_req_i = 0;
    dc_rd_req_i = 0;

    // Icache cached refill
    ic_rd_req_i = 1; ic_rd_addr_i = 32'h1C00_0014; ic_rd_single_i = 0;
    settle();
    chk("ic_refill_rdy", {63'd0, ic_rd_rdy_o}, 64'd1);
    chk("ic_refill_dc_rdy", {63'd0, dc_rd_rdy_o}, 64'd0);
    tick();
    ic_rd_req_i = 0;
    settle();
    serve_read(1'b0, 32'h1C00_0010, 8'd3, 32'hA000_0000);

    // Uncached dcache read
    dc_rd_req_i = 1; dc_rd_addr_i = 32'hBFAF_8004; dc_rd_single_i = 1;
    settle();
    chk("dc_single_rdy", {63'd0, dc_rd_rdy_o}, 64'd1);
    tick();
    dc_rd_req_i = 0; dc_rd_single_i = 0;
    settle();
    serve_read(1'b1, 32'hBFAF_8004, 8'd0, 32'hCAFE_0000);

    // Line write, then an icache read of the same line held until after mem_wr_done
    for (int i = 0; i < int'(LW); i++) words[i] = 32'hD000_0000 + i;
    dc_wr_req_i = 1; dc_wr_addr_i = 32'h0000_1000; dc_wr_single_i = 0; dc_wr_strb_i = 4'h0;
    dc_wr_data_i = {words[3], words[2], words[1], words[0]};
    settle();
    chk("line_wr_rdy", {63'd0, dc_wr_rdy_o}, 64'd1);
    tick();
    dc_wr_req_i = 0;
    ic_rd_req_i = 1; ic_rd_addr_i = 32'h0000_1008; ic_rd_single_i = 0;
    settle();
    chk("line_wr_req", {63'd0, mem_wr_req_o}, 64'd1);
    chk("line_wr_addr", {32'd0, mem_wr_addr_o}, 64'h1000);
    chk("line_wr_len", {56'd0, mem_wr_len_o}, 64'd3);
    chk("hazard_addr_phase", {63'd0, ic_rd_rdy_o}, 64'd0);
    mem_wr_ready_i = 1;
    tick();
    mem_wr_ready_i = 0;
    settle();
    chk("line_wr_stall_data", {32'd0, mem_wr_data_o}, {32'd0, words[0]});
    tick();
    for (int i = 0; i < int'(LW); i++) begin
      mem_wr_data_ready_i = 1;
      settle();
      chk("line_wr_valid", {63'd0, mem_wr_valid_o}, 64'd1);
      chk("line_wr_data", {32'd0, mem_wr_data_o}, {32'd0, words[i]});
      chk("line_wr_last", {63'd0, mem_wr_last_o}, {63'd0, (i == int'(LW) - 1)});
      chk("line_wr_strb", {60'd0, mem_wr_strb_o}, 64'hF);
      chk("hazard_data_phase", {63'd0, ic_rd_rdy_o}, 64'd0);
      tick();
    end
    mem_wr_data_ready_i = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("hazard_resp_wait", {63'd0, ic_rd_rdy_o}, 64'd0);
      tick();
    end
    mem_wr_done_i = 1;
    settle();
    chk("hazard_done_cycle", {63'd0, ic_rd_rdy_o}, 64'd0);
    tick();
    mem_wr_done_i = 0;
    settle();
    chk("hazard_released", {63'd0, ic_rd_rdy_o}, 64'd1);
    tick();
    ic_rd_req_i = 0;
    settle();
    serve_read(1'b0, 32'h0000_1000, 8'd3, 32'h5000_0000);

    // Uncached store
    dc_wr_req_i = 1; dc_wr_addr_i = 32'h2000_0006; dc_wr_single_i = 1; dc_wr_strb_i = 4'b0011;
    dc_wr_data_i = '0;
    dc_wr_data_i[31:0] = 32'h0000_1234;
    settle();
    chk("st_wr_rdy", {63'd0, dc_wr_rdy_o}, 64'd1);
    tick();
    dc_wr_req_i = 0; dc_wr_single_i = 0;
    settle();
    chk("st_wr_addr", {32'd0, mem_wr_addr_o}, 64'h2000_0004);
    chk("st_wr_len", {56'd0, mem_wr_len_o}, 64'd0);
    mem_wr_ready_i = 1;
    tick();
    mem_wr_ready_i = 0;
    settle();
    chk("st_wr_valid", {63'd0, mem_wr_valid_o}, 64'd1);
    chk("st_wr_last", {63'd0, mem_wr_last_o}, 64'd1);
    chk("st_wr_strb", {60'd0, mem_wr_strb_o}, 64'h3);
    chk("st_wr_data", {32'd0, mem_wr_data_o}, 64'h1234);
    mem_wr_data_ready_i = 1;
    tick();
    mem_wr_data_ready_i = 0;
    settle();
    chk("st_wr_after_last", {63'd0, mem_wr_valid_o}, 64'd0);
    mem_wr_done_i = 1;
    tick();
    mem_wr_done_i = 0;
    dc_wr_req_i = 1;
    settle();
    chk("st_back_idle", {63'd0, dc_wr_rdy_o}, 64'd1);
    dc_wr_req_i = 0;

    // Reset during beat 2 of a refill
    ic_rd_req_i = 1; ic_rd_addr_i = 32'h0000_3000; ic_rd_single_i = 0;
    settle();
    chk("rst_mid_rdy", {63'd0, ic_rd_rdy_o}, 64'd1);
    tick();
    ic_rd_req_i = 0;
    mem_rd_ready_i = 1;
    tick();
    mem_rd_ready_i = 0;
    mem_rd_valid_i = 1; mem_rd_data_i = 32'h7700_0000; mem_rd_last_i = 0;
    exp_q.push_back('{own: 1'b0, data: 32'h7700_0000, last: 1'b0});
    settle();
    check_beat();
    tick();
    mem_rd_data_i = 32'h7700_0001;
    reset_i = 1;
    tick();
    reset_i = 0;
    settle();
    chk("rst_mid_ic_ret", {63'd0, ic_ret_valid_o}, 64'd0);
    chk("rst_mid_ic_data", {32'd0, ic_ret_data_o}, 64'd0);
    chk("rst_mid_mem_rd_req", {63'd0, mem_rd_req_o}, 64'd0);
    chk("rst_mid_mem_wr_req", {63'd0, mem_wr_req_o}, 64'd0);
    mem_rd_valid_i = 0; mem_rd_data_i = 0;
    dc_rd_req_i = 1; dc_rd_addr_i = 32'h0000_4000; dc_rd_single_i = 1;
    settle();
    chk("rst_mid_new_rdy", {63'd0, dc_rd_rdy_o}, 64'd1);
    tick();
    dc_rd_req_i = 0; dc_rd_single_i = 0;
    settle();
    serve_read(1'b1, 32'h0000_4000, 8'd0, 32'h4444_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single external memory port between the instruction cache and the data cache behind the MMU. It accepts line refills and uncached single-word reads from both caches, plus line write-backs and uncached stores from the dcache. It serialises them into one read channel and one write channel, routes return beats to the owning cache, and holds any read that hits a still-pending write.

## Interface
- LINE_WORDS, 4: 32-bit words per cache line (burst length for cached requests); power of two ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock; fixed polarity and synchronicity
- ic_rd_req / dc_rd_req  in  1  read request from icache / dcache
- ic_rd_addr / dc_rd_addr  in  32  physical byte address; cached reads are line-aligned by the arbiter
- ic_rd_single / dc_rd_single  in  1  1 = uncached single-word read, 0 = line refill
- ic_rd_rdy / dc_rd_rdy  out  1  request accepted this cycle
- ic_ret_valid / dc_ret_valid  out  1  return beat valid
- ic_ret_last / dc_ret_last  out  1  final beat of the burst
- ic_ret_data / dc_ret_data  out  32  return beat data
- dc_wr_req  in  1  write request
- dc_wr_addr  in  32  physical byte address
- dc_wr_single  in  1  1 = uncached single word (word 0 of dc_wr_data), 0 = full line
- dc_wr_strb  in  4  byte strobe; applied to single writes; line writes use 4'hF
- dc_wr_data  in  32*LINE_WORDS  line data, word 0 in the LSBs
- dc_wr_rdy  out  1  write accepted (buffer captured)
- mem_rd_req  out  1  read address valid
- mem_rd_addr  out  32  read address
- mem_rd_len  out  8  beats−1 (0 or LINE_WORDS−1)
- mem_rd_ready  in  1  read address accepted
- mem_rd_valid / mem_rd_last  in  1  read beat valid / last beat
- mem_rd_data  in  32  read beat data
- mem_wr_req  out  1  write address valid
- mem_wr_addr  out  32  write address
- mem_wr_len  out  8  beats−1
- mem_wr_ready  in  1  write address accepted
- mem_wr_valid / mem_wr_last  out  1  write beat valid / last beat
- mem_wr_data  out  32  write beat data
- mem_wr_strb  out  4  write beat strobe
- mem_wr_data_ready  in  1  write beat accepted
- mem_wr_done  in  1  write response; the write is globally visible

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Only one read is outstanding at a time.
- Eligibility in R_IDLE: a requester is eligible when its req=1 and its line address (addr[31:log2(4*LINE_WORDS)]) does not match the write buffer line while the write FSM is not W_IDLE.
- Grant in R_IDLE:
  - Only one requester eligible: it wins.
  - Both eligible: round-robin via a 1-bit last_winner register; dcache wins after reset.
  - The winner's rd_rdy=1 combinationally in the same cycle.
  - On handshake, capture owner, address, and len. Cached address bits [log2(4*LINE_WORDS)-1:0] are zeroed; single reads keep the address with bits[1:0] zeroed. Next state R_ADDR.
- R_ADDR: mem_rd_req=1 with the captured address and len. On mem_rd_ready, go to R_DATA.
- R_DATA: mem_rd_valid/last/data are passed combinationally to the owner's ret_* and are 0 to the other cache. On a beat with mem_rd_last, go to R_IDLE.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
- dc_wr_rdy=1 only in W_IDLE. On handshake, capture the address (aligned as for reads), strb, single, and the data line. Next state W_ADDR.
- W_ADDR: mem_wr_req=1. On mem_wr_ready, go to W_DATA with beat counter=0.
- W_DATA: mem_wr_valid=1, mem_wr_data=word[counter], mem_wr_last=(counter==len).
  - On mem_wr_data_ready: if last, go to W_RESP; otherwise counter+1.
  - Counter width is log2(LINE_WORDS); it never wraps past len.
- W_RESP: wait for mem_wr_done, then go to W_IDLE.
- The read and write FSMs run concurrently and independently, except for the hazard block above.

## Timing
- Reset values: all outputs 0; read FSM R_IDLE; write FSM W_IDLE; last_winner=icache (so dcache is preferred first); buffers cleared. A reset asserted mid-burst abandons the transfer in the following cycle.
- Earliest read: request handshake in cycle 0, mem_rd_req in cycle 1. Data latency from mem is zero-added.
- Back-to-back reads: after the last beat, the next rd_rdy is possible in the following cycle (a 1-cycle bubble in R_IDLE).
- Simultaneous dc_wr_req and dc_rd_req to the same line, write FSM idle:
  - The write is captured in that cycle.
  - The read is also accepted, because the hazard check uses the pre-capture state.
  - Ordering is therefore the dcache's responsibility for same-cycle requests.
- A read that hits the write buffer is held with rd_rdy=0 through the mem_wr_done cycle. It is eligible the cycle after.
- mem_rd_valid outside R_DATA is ignored. mem_wr_done outside W_RESP is ignored.

## Structure
- Shared package: read-state and write-state enums, a line-offset-width constant derived from LINE_WORDS, and a rd_req_t struct (addr, single, owner).
- Natural sub-module: mem_wr_buf. It holds the write buffer, the write FSM, the beat counter, and the hazard line-compare output. The read FSM and arbiter stay in the top.

## Test plan
- Icache only, addr 0x1C000014, cached → mem_rd_addr=0x1C000010, len=3; 4 beats routed to ic_ret with last on beat 4; dc_ret_valid stays 0.
- Both caches request continuously for 3 grants after reset → grant order dcache, icache, dcache.
- Uncached dcache read at 0xBFAF8004 → mem_rd_len=0 and one beat with dc_ret_last=1.
- Line write at 0x00001000, then an icache read at 0x00001008 while mem_wr_done is withheld 10 cycles → ic_rd_rdy=0 until the cycle after mem_wr_done.
- Uncached store, strb 4'b0011, data 0x1234 → one beat with mem_wr_len=0, mem_wr_last=1, strb=0011.
- Reset asserted during beat 2 of a refill → next cycle all outputs 0 and both FSMs idle; a new request is accepted normally.
